// File: rtl/col_window_buf_pkg.sv
// Shared definitions for the vertical window builder.
//   state_t      : PRIME (filling line RAMs) / STREAM (emitting column vectors)
//   flags_t      : stream flag bundle; a full stream beat is {eor, eof, data},
//                  the same order row_pe uses on its output side
//   safe_clog2() : $clog2 that never returns 0, so width-1 vectors stay legal
package col_window_buf_pkg;

  typedef enum logic {
    ST_PRIME  = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic eor;
    logic eof;
  } flags_t;

  function automatic int safe_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/col_window_buf_line_ram.sv
// One row of pixel history: 1 write / 1 read port, DEPTH x DATA_W.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : pixel to store
//   rdata : pixel currently stored at addr (combinational read, so a read
//           and a write at the same address in one cycle return the old pixel)
module col_window_buf_line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/col_window_buf.sv
// Vertical window builder: keeps the last KERNEL_H-1 rows of the row-convolved
// stream in line RAMs and, once enough rows are buffered, emits one
// KERNEL_H-tall column vector per accepted pixel ("valid" convolution, no
// vertical padding).
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_vld/o_rdy           : input handshake; i_eor/i_eof row/frame markers
//   i_data                : input pixel
//   o_vld/i_rdy           : output handshake; o_eor/o_eof row/frame markers
//   o_data                : column vector, slice k = pixel from row r-k
//   o_err                 : sticky row-width error, cleared at frame end
module col_window_buf
  import col_window_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int KERNEL_H  = 7,
  parameter int MAX_ROW_W = 640
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_vld,
  input  logic                       i_eor,
  input  logic                       i_eof,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       o_rdy,
  input  logic                       i_rdy,
  output logic                       o_vld,
  output logic                       o_eor,
  output logic                       o_eof,
  output logic [KERNEL_H*DATA_W-1:0] o_data,
  output logic                       o_err
);

  localparam int NB     = KERNEL_H - 1;
  localparam int COL_W  = safe_clog2(MAX_ROW_W);
  localparam int ROW_CW = safe_clog2(KERNEL_H);
  localparam int BANK_W = safe_clog2(NB);

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(MAX_ROW_W - 1);
  localparam logic [ROW_CW-1:0] ROWS_FULL = ROW_CW'(NB);
  localparam logic [ROW_CW-1:0] ROWS_PRE  = ROW_CW'(NB - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NB - 1);

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [COL_W-1:0]    last_col;
  logic [ROW_CW-1:0]   rows;
  logic [BANK_W-1:0]   wr_bank;

  logic                accept_p0;
  logic                frame_end_p0;
  logic [DATA_W-1:0]   rd_data [NB];
  logic [KERNEL_H*DATA_W-1:0] window_p0;
  int                  bank_idx;

  logic                vld_p1;
  flags_t              flags_p1;
  logic [KERNEL_H*DATA_W-1:0] data_p1;

  // Stage 0: accept, line RAM access and window assembly
  assign o_rdy        = !vld_p1 || i_rdy;
  assign accept_p0    = i_vld && o_rdy;
  assign frame_end_p0 = i_eof && i_eor;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    col_window_buf_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_ROW_W),
      .ADDR_W (COL_W)
    ) u_line_ram (
      .clk   (i_clk),
      .we    (accept_p0 && (wr_bank == BANK_W'(b))),
      .addr  (col),
      .wdata (i_data),
      .rdata (rd_data[b])
    );
  end

  // Row r lands in bank r mod NB, so row r-k sits in bank (wr_bank-k) mod NB.
  // For k = NB that is wr_bank itself, read out just before it is overwritten.
  always_comb begin
    window_p0 = '0;
    bank_idx  = 0;
    window_p0[DATA_W-1:0] = i_data;
    for (int k = 1; k <= NB; k++) begin
      bank_idx = (int'(wr_bank) + NB - k) % NB;
      window_p0[k*DATA_W +: DATA_W] = rd_data[bank_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_PRIME;
      col      <= '0;
      last_col <= '0;
      rows     <= '0;
      wr_bank  <= '0;
      o_err    <= 1'b0;
    end else if (accept_p0) begin
      if (frame_end_p0) begin
        state   <= ST_PRIME;
        col     <= '0;
        rows    <= '0;
        wr_bank <= '0;
        o_err   <= 1'b0;
      end else if (i_eor) begin
        col <= '0;
        // The first row of a frame defines the width all later rows must match.
        if (rows == '0) begin
          last_col <= col;
        end else if (col != last_col) begin
          o_err <= 1'b1;
        end
        if (rows != ROWS_FULL) begin
          rows <= rows + 1'b1;
        end
        if (rows == ROWS_PRE) begin
          state <= ST_STREAM;
        end
        wr_bank <= (wr_bank == BANK_LAST) ? '0 : wr_bank + 1'b1;
      end else if (col == COL_MAX) begin
        // Row longer than the line RAM: hold the last column and keep going.
        o_err <= 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage 1: output register, held while the downstream stalls
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1   <= 1'b0;
      flags_p1 <= '0;
      data_p1  <= '0;
    end else if (accept_p0 && (state == ST_STREAM)) begin
      vld_p1       <= 1'b1;
      flags_p1.eor <= i_eor;
      flags_p1.eof <= frame_end_p0;
      data_p1      <= window_p0;
    end else if (i_rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  assign o_vld  = vld_p1;
  assign o_eor  = flags_p1.eor;
  assign o_eof  = flags_p1.eof;
  assign o_data = data_p1;

endmodule
